mano_mem_ctrl: RTL and testbench



---
 rtl/mano_mem_pkg.sv | 21 ++
 rtl/mano_mem_decode.sv | 35 +++
 rtl/mano_mem_ctrl.sv | 112 +++++++++++
 tb/tb_mano_mem_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mano_mem_pkg.sv
// Shared types and constants for the Mano basic-computer memory-access controller.
package mano_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int unsigned ADDR_W_DEF = 12;
   localparam int unsigned DATA_W_DEF = 16;

   localparam int unsigned D_AND = 0;
   localparam int unsigned D_ADD = 1;
   localparam int unsigned D_LDA = 2;
   localparam int unsigned D_STA = 3;
   localparam int unsigned D_BSA = 5;
   localparam int unsigned D_ISZ = 6;
   localparam int unsigned D_IO  = 7;

endpackage

// File: rtl/mano_mem_decode.sv
// Combinational read/write-needed decode from T, D, J and R.
// MANO_INT_CYCLE_EN: R&T1 becomes a write (interrupt return-address save).
module mano_mem_decode
   import mano_mem_pkg::*;
(
   input  logic [7:0] t_i,
   input  logic [7:0] d_i,
   input  logic       j_i,
   input  logic       r_i,
   output logic       rn_o,
   output logic       wn_o
);

   logic unused_bits;

   always_comb begin
      rn_o = (~d_i[D_IO] & j_i & t_i[3])
           | ((d_i[D_AND] | d_i[D_ADD] | d_i[D_LDA] | d_i[D_ISZ]) & t_i[4]);
      wn_o = ((d_i[D_STA] | d_i[D_BSA]) & t_i[4])
           | (d_i[D_ISZ] & t_i[6]);
`ifdef MANO_INT_CYCLE_EN
      rn_o = rn_o | (~r_i & t_i[1]);
      wn_o = wn_o | (r_i & t_i[1]);
`else
      rn_o = rn_o | t_i[1];
`endif
   end

`ifdef MANO_INT_CYCLE_EN
   assign unused_bits = ^{t_i[0], t_i[2], t_i[5], t_i[7], d_i[4]};
`else
   assign unused_bits = ^{t_i[0], t_i[2], t_i[5], t_i[7], d_i[4], r_i};
`endif

endmodule

// File: rtl/mano_mem_ctrl.sv
// Request/acknowledge memory-access sequencer that stalls SC until the access ends.
// Optional MANO_INT_CYCLE_EN affects only the decode sub-module.
module mano_mem_ctrl
   import mano_mem_pkg::*;
#(
   parameter int unsigned ADDR_W  = ADDR_W_DEF,
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic [7:0]        T,
   input  logic [7:0]        D,
   input  logic              J,
   input  logic              R,
   input  logic [ADDR_W-1:0] AR,
   input  logic [DATA_W-1:0] WDATA,
   output logic              STALL,
   output logic              MEM_REQ,
   output logic              MEM_WE,
   output logic [ADDR_W-1:0] MEM_ADDR,
   output logic [DATA_W-1:0] MEM_WDATA,
   input  logic [DATA_W-1:0] MEM_RDATA,
   input  logic              MEM_ACK,
   output logic [DATA_W-1:0] RD_DATA,
   output logic              RD_VALID,
   output logic              ERR
);

   state_e            state_q;
   logic [7:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rd_data_q;
   logic              we_q, req_q, stall_q, rd_valid_q, err_q;
   logic              rn, wn, need, timeout_hit;

   mano_mem_decode u_decode (
      .t_i  (T),
      .d_i  (D),
      .j_i  (J),
      .r_i  (R),
      .rn_o (rn),
      .wn_o (wn)
   );

   assign need        = rn | wn;
   assign cnt_d       = cnt_q + 8'd1;
   assign timeout_hit = (cnt_q == 8'(TIMEOUT - 1));

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rd_data_q  <= '0;
         we_q       <= 1'b0;
         req_q      <= 1'b0;
         stall_q    <= 1'b0;
         rd_valid_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         rd_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (need) begin
                  addr_q  <= AR;
                  wdata_q <= WDATA;
                  we_q    <= wn;
                  req_q   <= 1'b1;
                  stall_q <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= REQ;
               end
            end
            REQ: begin
               cnt_q <= cnt_d;
               // ACK wins over a simultaneous timeout
               if (MEM_ACK || timeout_hit) begin
                  if (MEM_ACK) begin
                     if (!we_q) begin
                        rd_data_q  <= MEM_RDATA;
                        rd_valid_q <= 1'b1;
                     end
                  end else begin
                     err_q      <= 1'b1;
                     rd_data_q  <= '0;
                     rd_valid_q <= ~we_q;
                  end
                  req_q   <= 1'b0;
                  we_q    <= 1'b0;
                  stall_q <= 1'b0;
                  state_q <= DONE;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign STALL     = stall_q | ((state_q == IDLE) & need);
   assign MEM_REQ   = req_q;
   assign MEM_WE    = we_q;
   assign MEM_ADDR  = addr_q;
   assign MEM_WDATA = wdata_q;
   assign RD_DATA   = rd_data_q;
   assign RD_VALID  = rd_valid_q;
   assign ERR       = err_q;

endmodule

// File: tb/tb_mano_mem_ctrl.sv
// Scoreboard bench for mano_mem_ctrl: stimulus queues expected handshakes, a monitor checks them.
module tb_mano_mem_ctrl;

   localparam int unsigned AW = 12;
   localparam int unsigned DW = 16;
   localparam int unsigned TO = 15;

   logic          CLK = 1'b0;
   logic          RST_N;
   logic [7:0]    T, D;
   logic          J, R;
   logic [AW-1:0] AR;
   logic [DW-1:0] WDATA;
   logic          STALL, MEM_REQ, MEM_WE;
   logic [AW-1:0] MEM_ADDR;
   logic [DW-1:0] MEM_WDATA, MEM_RDATA, RD_DATA;
   logic          MEM_ACK, RD_VALID, ERR;

   always #5 CLK = ~CLK;

   mano_mem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .CLK(CLK), .RST_N(RST_N), .T(T), .D(D), .J(J), .R(R), .AR(AR), .WDATA(WDATA),
      .STALL(STALL), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
      .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK),
      .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .ERR(ERR)
   );

   typedef struct {
      logic [AW-1:0] addr;
      logic          we;
      logic [DW-1:0] wdata;
      int            len;
   } req_t;

   req_t          exp_req_q[$];
   logic [DW-1:0] exp_rd_q[$];
   int            checks = 0;
   int            errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Memory responder: ACK after ack_wait extra REQ cycles; optional stray ACK while idle
   int            ack_wait = 0;
   int            rcnt = 0;
   logic [DW-1:0] ack_data = '0;
   logic          stray_ack = 1'b0;

   initial begin
      MEM_ACK   = 1'b0;
      MEM_RDATA = '0;
      forever begin
         @(negedge CLK);
         if (MEM_REQ) begin
            MEM_ACK   = (rcnt == ack_wait);
            MEM_RDATA = ack_data;
            rcnt++;
         end else begin
            rcnt    = 0;
            MEM_ACK = stray_ack;
            if (stray_ack) MEM_RDATA = 16'h1234;
            stray_ack = 1'b0;
         end
      end
   end

   // Monitor
   req_t cur;
   bit   prev_req = 1'b0;
   bit   held = 1'b1;
   int   len = 0;

   initial begin
      forever begin
         @(negedge CLK);
         if (MEM_REQ && !prev_req) begin
            if (exp_req_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL req_unexpected actual addr=%0h we=%0b required none", MEM_ADDR, MEM_WE);
               cur.addr = MEM_ADDR; cur.we = MEM_WE; cur.wdata = MEM_WDATA; cur.len = 0;
            end else begin
               cur = exp_req_q.pop_front();
               check("req_addr", 32'(MEM_ADDR), 32'(cur.addr));
               check("req_we", 32'(MEM_WE), 32'(cur.we));
               if (cur.we) check("req_wdata", 32'(MEM_WDATA), 32'(cur.wdata));
            end
            len  = 0;
            held = 1'b1;
         end
         if (MEM_REQ) begin
            len++;
            if (MEM_WE !== cur.we || (cur.we && MEM_WDATA !== cur.wdata)) held = 1'b0;
         end
         if (!MEM_REQ && prev_req) begin
            if (cur.len != 0) check("req_len", 32'(len), 32'(cur.len));
            check("req_held", 32'(held), 32'd1);
         end
         if (RD_VALID) begin
            if (exp_rd_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL rd_unexpected actual=%0h required no RD_VALID", RD_DATA);
            end else begin
               check("rd_data", 32'(RD_DATA), 32'(exp_rd_q.pop_front()));
            end
         end
         prev_req = MEM_REQ;
      end
   end

   // One T state with its expected handshake; waits >= TO means the memory never answers
   task automatic access(input string name, input logic [7:0] t, input logic [7:0] d,
                         input logic j, input logic r, input logic [AW-1:0] ar,
                         input logic [DW-1:0] wd, input int waits, input logic [DW-1:0] rdata,
                         input bit exp_req, input bit exp_we);
      req_t e;
      int   n, exp_stall;
      bit   tmo;
      tmo = (waits >= int'(TO));
      @(negedge CLK);
      ack_wait = waits;
      ack_data = rdata;
      if (exp_req) begin
         e.addr = ar; e.we = exp_we; e.wdata = wd;
         e.len  = tmo ? int'(TO) : waits + 1;
         exp_req_q.push_back(e);
         if (!exp_we) exp_rd_q.push_back(tmo ? 16'h0000 : rdata);
      end
      exp_stall = !exp_req ? 0 : (tmo ? int'(TO) + 1 : waits + 2);
      T = t; D = d; J = j; R = r; AR = ar; WDATA = wd;
      #1;
      n = 0;
      while (STALL && n < 200) begin
         n++;
         @(negedge CLK);
         AR = ~ar; WDATA = ~wd;
         #1;
      end
      check({name, "_stall"}, 32'(n), 32'(exp_stall));
      T = '0; D = '0; J = 1'b0; R = 1'b0;
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_req"}, 32'(MEM_REQ), 32'd0);
      check({name, "_we"}, 32'(MEM_WE), 32'd0);
      check({name, "_stall"}, 32'(STALL), 32'd0);
      check({name, "_addr"}, 32'(MEM_ADDR), 32'd0);
      check({name, "_wdata"}, 32'(MEM_WDATA), 32'd0);
      check({name, "_rddata"}, 32'(RD_DATA), 32'd0);
      check({name, "_rdvalid"}, 32'(RD_VALID), 32'd0);
      check({name, "_err"}, 32'(ERR), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      RST_N = 1'b0; T = '0; D = '0; J = 1'b0; R = 1'b0; AR = '0; WDATA = '0;
      #23;
      check_all_zero("reset");
      @(negedge CLK);
      RST_N = 1'b1;

      access("fetch", 8'h02, 8'h00, 1'b0, 1'b0, 12'h010, 16'h0000, 0, 16'h7800, 1'b1, 1'b0);
      access("sta", 8'h10, 8'h08, 1'b0, 1'b0, 12'h123, 16'hBEEF, 2, 16'h0000, 1'b1, 1'b1);
      check("sta_rd_kept", 32'(RD_DATA), 32'h7800);
      access("indirect", 8'h08, 8'h04, 1'b1, 1'b0, 12'h055, 16'h0000, 1, 16'h0A0B, 1'b1, 1'b0);
      access("io_t3", 8'h08, 8'h80, 1'b1, 1'b0, 12'h066, 16'h0000, 0, 16'h0000, 1'b0, 1'b0);
      access("isz_t4", 8'h10, 8'h40, 1'b0, 1'b0, 12'h200, 16'h0000, 0, 16'h00FF, 1'b1, 1'b0);
      access("isz_t5", 8'h20, 8'h40, 1'b0, 1'b0, 12'h200, 16'h0000, 0, 16'h0000, 1'b0, 1'b0);
      access("isz_t6", 8'h40, 8'h40, 1'b0, 1'b0, 12'h200, 16'h0001, 1, 16'h0000, 1'b1, 1'b1);
      access("bsa_t4", 8'h10, 8'h20, 1'b0, 1'b0, 12'h300, 16'h0ABC, 0, 16'h0000, 1'b1, 1'b1);
      access("ack_at_limit", 8'h10, 8'h04, 1'b0, 1'b0, 12'h0F0, 16'h0000, int'(TO) - 1, 16'h5A5A, 1'b1, 1'b0);
      check("err_clear", 32'(ERR), 32'd0);

      access("timeout", 8'h10, 8'h04, 1'b0, 1'b0, 12'h3FF, 16'h0000, 1000, 16'hDEAD, 1'b1, 1'b0);
      check("timeout_err", 32'(ERR), 32'd1);
      check("timeout_rd", 32'(RD_DATA), 32'd0);

      @(negedge CLK);
      stray_ack = 1'b1;
      repeat (3) @(negedge CLK);
      #1;
      check("stray_req", 32'(MEM_REQ), 32'd0);
      check("stray_err", 32'(ERR), 32'd1);
      check("stray_rd", 32'(RD_DATA), 32'd0);

`ifdef MANO_INT_CYCLE_EN
      access("int_t1", 8'h02, 8'h00, 1'b0, 1'b1, 12'h001, 16'h0123, 0, 16'h4444, 1'b1, 1'b1);
`else
      access("int_t1", 8'h02, 8'h00, 1'b0, 1'b1, 12'h001, 16'h0123, 0, 16'h4444, 1'b1, 1'b0);
`endif

      // Reset while the memory keeps the request waiting
      @(negedge CLK);
      begin
         req_t e;
         e.addr = 12'h0AA; e.we = 1'b0; e.wdata = '0; e.len = 0;
         exp_req_q.push_back(e);
      end
      ack_wait = 1000;
      T = 8'h02; AR = 12'h0AA;
      repeat (3) @(negedge CLK);
      #2;
      RST_N = 1'b0;
      #1;
      T = '0;
      #1;
      check_all_zero("midreq_reset");
      @(negedge CLK);
      RST_N = 1'b1;

      access("refetch", 8'h02, 8'h00, 1'b0, 1'b0, 12'h011, 16'h0000, 1, 16'hC0DE, 1'b1, 1'b0);

      repeat (5) @(negedge CLK);
      check("req_queue_empty", 32'(exp_req_q.size()), 32'd0);
      check("rd_queue_empty", 32'(exp_rd_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
